seven_seg_scan_ctrl: RTL

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_pkg.sv | 28 ++
 rtl/scan_tick_counter.sv | 26 ++
 rtl/seven_seg_scan_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_MAX    = 9;
    localparam int TICK_W     = 20;

    // A digit is lit when its nibble is a legal BCD value and, with leading-zero
    // suppression on, some nibble at or above it is non-zero (digit 0 always shows).
    function automatic logic digit_lit(input logic [15:0] data,
                                       input logic [1:0]  idx,
                                       input logic        lz_en);
        logic hi_nz;
        hi_nz = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && data[4*k +: 4] != 4'h0) hi_nz = 1'b1;
        end
        if (data[4*idx +: 4] > 4'(BCD_MAX)) return 1'b0;
        return !(lz_en && idx != 2'd0 && !hi_nz);
    endfunction

endpackage

// File: rtl/scan_tick_counter.sv
// Loadable down-counter; done is high while the count sits at zero, which the
// FSM sees for exactly one cycle because it reloads on that cycle.
module scan_tick_counter #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Clear has priority over load; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               cnt <= '0;
        else if (clr)             cnt <= '0;
        else if (load)            cnt <= load_val;
        else if (cnt != '0)       cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for a 4-digit common-anode display. digit_code and
// dot_out go straight to an external seven_seg decoder; no segment decode here.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 4,
    parameter bit LZ_SUPPRESS  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dots,
    output logic [3:0]  digit_code,
    output logic        dot_out,
    output logic [3:0]  anode_n,
    output logic        frame_start,
    output logic        pending
);

    localparam logic [TICK_W-1:0] SHOW_LOAD  = TICK_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] BLANK_LOAD = TICK_W'(BLANK_CYCLES - 1);

    scan_state_t        state, state_n;
    logic [1:0]         idx, idx_n;
    logic               tick_load, tick_clr, tick_done;
    logic [TICK_W-1:0]  tick_val;
    logic [15:0]        shadow_data, act_data, act_data_n;
    logic [3:0]         shadow_dots, act_dots, act_dots_n;
    logic               xfer;
    logic [3:0]         anode_d, code_d;
    logic               dot_d, fs_d;

    scan_tick_counter #(.W(TICK_W)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tick_clr),
        .load     (tick_load),
        .load_val (tick_val),
        .done     (tick_done)
    );

    // State and digit index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 2'd0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Next-state: IDLE -> BLANK -> SHOW -> BLANK(next digit); enable low wins.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        tick_load = 1'b0;
        tick_clr  = 1'b0;
        tick_val  = BLANK_LOAD;
        if (!enable) begin
            state_n  = IDLE;
            idx_n    = 2'd0;
            tick_clr = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_n   = BLANK;
                    idx_n     = 2'd0;
                    tick_load = 1'b1;
                end
                BLANK: if (tick_done) begin
                    state_n   = SHOW;
                    tick_load = 1'b1;
                    tick_val  = SHOW_LOAD;
                end
                SHOW: if (tick_done) begin
                    state_n   = BLANK;
                    idx_n     = idx + 2'd1;
                    tick_load = 1'b1;
                end
                default: begin
                    state_n  = IDLE;
                    idx_n    = 2'd0;
                    tick_clr = 1'b1;
                end
            endcase
        end
    end

    // The frame boundary transfer happens on the edge that closes the
    // frame_start cycle, so a load strobed alongside frame_start lands directly
    // in the active register. act_*_n is used by the output mux so a one-cycle
    // blank still shows the freshly transferred data.
    always_comb begin
        xfer       = enable && frame_start;
        act_data_n = act_data;
        act_dots_n = act_dots;
        if (xfer) begin
            act_data_n = load ? load_data : shadow_data;
            act_dots_n = load ? load_dots : shadow_dots;
        end
    end

    // Shadow/active data and pending flag; retained across enable=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data <= 16'h0;
            shadow_dots <= 4'h0;
            act_data    <= 16'h0;
            act_dots    <= 4'h0;
            pending     <= 1'b0;
        end else begin
            if (load) begin
                shadow_data <= load_data;
                shadow_dots <= load_dots;
            end
            act_data <= act_data_n;
            act_dots <= act_dots_n;
            if (xfer)      pending <= 1'b0;
            else if (load) pending <= 1'b1;
        end
    end

    // Output values for the state being entered, so they move with the state.
    always_comb begin
        anode_d = 4'hF;
        code_d  = 4'h0;
        dot_d   = 1'b0;
        fs_d    = (state_n == BLANK) && (state != BLANK) && (idx_n == 2'd0);
        if (state_n == SHOW) begin
            code_d = act_data_n[4*idx_n +: 4];
            dot_d  = act_dots_n[idx_n];
            if (digit_lit(act_data_n, idx_n, LZ_SUPPRESS))
                anode_d = ~(4'b0001 << idx_n);
        end
    end

    // Output register: anode, code and dot change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_n     <= 4'hF;
            digit_code  <= 4'h0;
            dot_out     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            anode_n     <= anode_d;
            digit_code  <= code_d;
            dot_out     <= dot_d;
            frame_start <= fs_d;
        end
    end

endmodule
